// File: rtl/wbc_pkg.sv
// wbc_pkg: shared constants, master indices and state encoding
// for the WISHBONE control-bus scheduler.
package wbc_pkg;

    localparam int NUM_MASTERS_DEF    = 5;
    localparam int TIMEOUT_CYCLES_DEF = 1024;

    localparam int PCIC  = 0;
    localparam int TURFC = 1;
    localparam int HKMC  = 2;
    localparam int WBVIO = 3;
    localparam int DMAD  = 4;

    typedef enum logic [1:0] {
        S_IDLE,
        S_GRANT,
        S_ABORT,
        S_DRAIN
    } wbc_state_e;

endpackage

// File: rtl/wbc_rr_select.sv
// wbc_rr_select: round-robin pick of the first requester after
// the rotation pointer, wrapping modulo N.
module wbc_rr_select
    import wbc_pkg::*;
#(
    parameter int N  = NUM_MASTERS_DEF,
    parameter int PW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic          valid
);

    logic [PW-1:0] idx;

    always_comb begin
        pick  = '0;
        valid = 1'b0;
        idx   = ptr;
        for (int i = 0; i < N; i++) begin
            idx = (idx == PW'(N - 1)) ? '0 : idx + PW'(1);
            if (!valid && req[idx]) begin
                pick[idx] = 1'b1;
                valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/wbc_bus_scheduler.sv
// wbc_bus_scheduler: round-robin owner of the shared control bus
// with a stalled-strobe watchdog that aborts and drains hung tenures.
module wbc_bus_scheduler
    import wbc_pkg::*;
#(
    parameter int NUM_MASTERS    = NUM_MASTERS_DEF,
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
    parameter int CNT_W          = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_n_i,
    input  logic [NUM_MASTERS-1:0] cyc_i,
    input  logic                   stb_i,
    input  logic                   ack_i,
    input  logic                   err_i,
    input  logic                   rty_i,
    output logic [NUM_MASTERS-1:0] gnt_o,
    output logic                   bus_kill_o,
    output logic                   timeout_err_o,
    output logic [CNT_W-1:0]       timeout_cnt_o,
    output logic [NUM_MASTERS-1:0] timeout_gnt_o
);

    localparam int PW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);
    localparam logic [TW-1:0] WD_LAST =
        TW'(WD_EN ? TIMEOUT_CYCLES - 1 : 0);

    wbc_state_e state_q;
    wbc_state_e state_d;

    logic [NUM_MASTERS-1:0] gnt_d;
    logic [NUM_MASTERS-1:0] tgnt_d;
    logic [NUM_MASTERS-1:0] pick;
    logic [PW-1:0]          ptr_q;
    logic [PW-1:0]          ptr_d;
    logic [PW-1:0]          pick_idx;
    logic [TW-1:0]          wd_q;
    logic [TW-1:0]          wd_d;
    logic [CNT_W-1:0]       cnt_d;
    logic                   pick_vld;
    logic                   own_cyc;
    logic                   term;
    logic                   rearb;

    wbc_rr_select #(
        .N  (NUM_MASTERS),
        .PW (PW)
    ) u_sel (
        .req   (cyc_i),
        .ptr   (ptr_q),
        .pick  (pick),
        .valid (pick_vld)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick[i]) pick_idx = PW'(i);
        end
    end

    assign own_cyc       = |(gnt_o & cyc_i);
    assign term          = ack_i | err_i | rty_i;
    assign timeout_err_o = (state_q == S_ABORT);
    assign bus_kill_o    = (state_q == S_ABORT) || (state_q == S_DRAIN);

    always_comb begin
        state_d = state_q;
        gnt_d   = gnt_o;
        ptr_d   = ptr_q;
        wd_d    = '0;
        cnt_d   = timeout_cnt_o;
        tgnt_d  = timeout_gnt_o;
        rearb   = 1'b0;
        unique case (state_q)
            S_IDLE: rearb = 1'b1;
            S_GRANT: begin
                if (!own_cyc) begin
                    rearb = 1'b1;
                end else if (WD_EN && stb_i && !term) begin
                    if (wd_q == WD_LAST) state_d = S_ABORT;
                    else wd_d = wd_q + TW'(1);
                end
            end
            S_ABORT: begin
                state_d = S_DRAIN;
                tgnt_d  = gnt_o;
                if (!(&timeout_cnt_o)) cnt_d = timeout_cnt_o + CNT_W'(1);
            end
            // slave is already killed, so late terminations are ignored
            S_DRAIN: rearb = !own_cyc;
            default: ;
        endcase
        if (rearb) begin
            gnt_d   = pick;
            state_d = pick_vld ? S_GRANT : S_IDLE;
            if (pick_vld) ptr_d = pick_idx;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q       <= S_IDLE;
            gnt_o         <= '0;
            ptr_q         <= PW'(NUM_MASTERS - 1);
            wd_q          <= '0;
            timeout_cnt_o <= '0;
            timeout_gnt_o <= '0;
        end else begin
            state_q       <= state_d;
            gnt_o         <= gnt_d;
            ptr_q         <= ptr_d;
            wd_q          <= wd_d;
            timeout_cnt_o <= cnt_d;
            timeout_gnt_o <= tgnt_d;
        end
    end

endmodule

// File: tb/tb_wbc_bus_scheduler.sv
// tb_wbc_bus_scheduler: randomized and directed checks of the bus
// scheduler against a queue-free arithmetic ownership model.
module tb_wbc_bus_scheduler;

    localparam int N  = 5;
    localparam int TO = 16;
    localparam int CW = 16;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] cyc;
    logic         stb, ack, err, rty;
    logic [N-1:0] gnt_o, timeout_gnt_o;
    logic         bus_kill_o, timeout_err_o;
    logic [CW-1:0] timeout_cnt_o;

    logic [N-1:0] s_cyc;
    logic         s_stb;
    logic [N-1:0] s_gnt, s_tgnt;
    logic         s_kill, s_terr;
    logic [3:0]   s_cnt;

    int errors = 0;
    int checks = 0;

    // model state
    int           m_own, m_ptr, m_stall, m_cnt;
    bit           m_abort, m_drain;
    logic [N-1:0] m_tgnt;

    logic [N-1:0] ord [$];
    logic [N-1:0] exp_ord [4];

    wire [27:0] act = {gnt_o, bus_kill_o, timeout_err_o,
                       timeout_cnt_o, timeout_gnt_o};

    always #5 clk = ~clk;

    wbc_bus_scheduler #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TO),
        .CNT_W          (CW)
    ) dut (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .cyc_i         (cyc),
        .stb_i         (stb),
        .ack_i         (ack),
        .err_i         (err),
        .rty_i         (rty),
        .gnt_o         (gnt_o),
        .bus_kill_o    (bus_kill_o),
        .timeout_err_o (timeout_err_o),
        .timeout_cnt_o (timeout_cnt_o),
        .timeout_gnt_o (timeout_gnt_o)
    );

    wbc_bus_scheduler #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (1),
        .CNT_W          (4)
    ) dut_sat (
        .clk_i         (clk),
        .rst_n_i       (rst_n),
        .cyc_i         (s_cyc),
        .stb_i         (s_stb),
        .ack_i         (1'b0),
        .err_i         (1'b0),
        .rty_i         (1'b0),
        .gnt_o         (s_gnt),
        .bus_kill_o    (s_kill),
        .timeout_err_o (s_terr),
        .timeout_cnt_o (s_cnt),
        .timeout_gnt_o (s_tgnt)
    );

    function automatic int next_req(input logic [N-1:0] c, input int from);
        logic [N-1:0] sh;
        for (int k = 1; k <= N; k++) begin
            sh = c >> ((from + k) % N);
            if (sh[0]) return (from + k) % N;
        end
        return -1;
    endfunction

    function automatic logic [27:0] exp_vec();
        logic [N-1:0] g;
        g = (m_own < 0) ? '0 : (N'(1) << m_own);
        return {g, m_abort | m_drain, m_abort, CW'(m_cnt), m_tgnt};
    endfunction

    task automatic model_reset();
        m_own   = -1;
        m_ptr   = N - 1;
        m_stall = 0;
        m_cnt   = 0;
        m_abort = 0;
        m_drain = 0;
        m_tgnt  = '0;
    endtask

    task automatic model_step();
        if (m_abort) begin
            m_abort = 0;
            m_drain = 1;
            if (m_cnt < (1 << CW) - 1) m_cnt++;
            m_tgnt = N'(1) << m_own;
        end else if (m_own < 0 || next_req(cyc & (N'(1) << m_own), m_own - 1) < 0) begin
            m_own = next_req(cyc, (m_own < 0) ? m_ptr : m_own);
            if (m_own >= 0) m_ptr = m_own;
            m_drain = 0;
            m_stall = 0;
        end else if (!m_drain) begin
            if (stb && !(ack || err || rty)) begin
                if (m_stall == TO - 1) begin
                    m_abort = 1;
                    m_stall = 0;
                end else begin
                    m_stall++;
                end
            end else begin
                m_stall = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc = '0; stb = 0; ack = 0; err = 0; rty = 0;
        s_cyc = '0; s_stb = 0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        cyc = 5'b11111; stb = 1; ack = 0; err = 0; rty = 0;
        s_cyc = '0; s_stb = 0;
        model_reset();
        #2;
        checks++;
        if (act !== 28'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h want 0", act);
        end
        @(posedge clk); #1;
        checks++;
        if (act !== 28'd0) begin
            errors++;
            $display("FAIL reset_held: got %h want 0", act);
        end
        cyc = '0;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (act !== exp_vec()) begin
            errors++;
            $display("FAIL reset_idle: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_single();
        do_reset();
        cyc = 5'b00001; stb = 1;
        for (int i = 0; i < 12; i++) begin
            ack = (i % 3 == 2);
            tick();
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL single_model: got %h want %h", act, exp_vec());
            end
            checks++;
            if (gnt_o !== 5'b00001 || timeout_err_o !== 1'b0) begin
                errors++;
                $display("FAIL single_hold: gnt %b err %b want 00001 0",
                         gnt_o, timeout_err_o);
            end
        end
        cyc = '0; stb = 0; ack = 0;
        tick();
        checks++;
        if (act !== exp_vec()) begin
            errors++;
            $display("FAIL single_release: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_rotation();
        logic [N-1:0] prev;
        int held, own;
        do_reset();
        exp_ord = '{5'b00001, 5'b00100, 5'b10000, 5'b00001};
        ord.delete();
        cyc = 5'b10101; stb = 1; ack = 1;
        prev = '0; held = 0; own = -1;
        for (int i = 0; i < 40; i++) begin
            tick();
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL rot_model: got %h want %h", act, exp_vec());
            end
            if (i > 0) begin
                checks++;
                if (gnt_o === '0) begin
                    errors++;
                    $display("FAIL rot_gap: got %b want nonzero", gnt_o);
                end
            end
            if (gnt_o !== prev) begin
                ord.push_back(gnt_o);
                prev = gnt_o;
            end
            if (ord.size() == 4) break;
            held = (m_own == own) ? held + 1 : 1;
            own = m_own;
            cyc = 5'b10101;
            if (held == 4) cyc = cyc & ~(N'(1) << own);
        end
        for (int k = 0; k < 4; k++) begin
            checks++;
            if (k >= ord.size() || ord[k] !== exp_ord[k]) begin
                errors++;
                $display("FAIL rot_order: step %0d got %b want %b", k,
                         (k < ord.size()) ? ord[k] : 5'bx, exp_ord[k]);
            end
        end
        cyc = '0; stb = 0; ack = 0;
        repeat (2) tick();
        checks++;
        if (act !== exp_vec()) begin
            errors++;
            $display("FAIL rot_end: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_timeout();
        int seen;
        do_reset();
        cyc = 5'b00010; stb = 1;
        seen = -1;
        for (int i = 1; i <= 40; i++) begin
            tick();
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL to_model: got %h want %h", act, exp_vec());
            end
            if (timeout_err_o === 1'b1 && seen < 0) seen = i;
            if (seen > 0 && i == seen + 1) begin
                checks++;
                if (timeout_err_o !== 1'b0) begin
                    errors++;
                    $display("FAIL to_pulse: got %b want 0", timeout_err_o);
                end
            end
            if (seen > 0 && i == seen + 3) break;
        end
        checks++;
        if (seen != 17) begin
            errors++;
            $display("FAIL to_when: got edge %0d want 17", seen);
        end
        checks++;
        if (timeout_cnt_o !== 16'd1 || timeout_gnt_o !== 5'b00010
            || bus_kill_o !== 1'b1) begin
            errors++;
            $display("FAIL to_capture: cnt %h gnt %b kill %b want 0001 00010 1",
                     timeout_cnt_o, timeout_gnt_o, bus_kill_o);
        end
        stb = 0;
        ack = 1;
        tick();
        checks++;
        if (bus_kill_o !== 1'b1 || gnt_o !== 5'b00010) begin
            errors++;
            $display("FAIL to_drain: kill %b gnt %b want 1 00010",
                     bus_kill_o, gnt_o);
        end
        cyc = '0; ack = 0;
        tick();
        checks++;
        if (act !== exp_vec() || bus_kill_o !== 1'b0) begin
            errors++;
            $display("FAIL to_release: got %h want %h", act, exp_vec());
        end
    endtask

    task automatic test_ack_terminal();
        do_reset();
        cyc = 5'b00010; stb = 1;
        repeat (16) tick();
        ack = 1;
        tick();
        checks++;
        if (timeout_err_o !== 1'b0 || bus_kill_o !== 1'b0) begin
            errors++;
            $display("FAIL ack_term: err %b kill %b want 0 0",
                     timeout_err_o, bus_kill_o);
        end
        ack = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL ack_after: got %h want %h", act, exp_vec());
            end
        end
        checks++;
        if (timeout_cnt_o !== 16'd0) begin
            errors++;
            $display("FAIL ack_cnt: got %h want 0", timeout_cnt_o);
        end
        cyc = '0; stb = 0;
        tick();
    endtask

    task automatic test_rst_drain();
        bit drained;
        do_reset();
        cyc = 5'b11111; stb = 1;
        drained = 0;
        for (int i = 0; i < 40 && !drained; i++) begin
            tick();
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL rd_model: got %h want %h", act, exp_vec());
            end
            drained = m_drain;
        end
        checks++;
        if (!drained || bus_kill_o !== 1'b1) begin
            errors++;
            $display("FAIL rd_reach: kill %b want 1", bus_kill_o);
        end
        repeat (2) tick();
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (act !== 28'd0) begin
            errors++;
            $display("FAIL rd_async: got %h want 0", act);
        end
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        checks++;
        if (gnt_o !== 5'b00001 || act !== exp_vec()) begin
            errors++;
            $display("FAIL rd_first: got %h want %h", act, exp_vec());
        end
        cyc = '0; stb = 0;
        repeat (2) tick();
    endtask

    task automatic test_random();
        logic [N-1:0] msk;
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            msk = '0;
            for (int b = 0; b < N; b++)
                msk = {msk[N-2:0], ($urandom_range(11) == 0)};
            cyc = cyc ^ msk;
            stb = ($urandom_range(7) != 0);
            ack = ($urandom_range(23) == 0);
            err = ($urandom_range(47) == 0);
            rty = ($urandom_range(47) == 0);
            tick();
            checks++;
            if (act !== exp_vec()) begin
                errors++;
                $display("FAIL rand_model: cyc %0d got %h want %h",
                         i, act, exp_vec());
            end
        end
        cyc = '0; stb = 0; ack = 0; err = 0; rty = 0;
        repeat (2) tick();
    endtask

    task automatic test_saturation();
        bit hit;
        int want;
        do_reset();
        s_stb = 1;
        for (int k = 1; k <= 20; k++) begin
            s_cyc = 5'b00001;
            hit = 0;
            for (int w = 0; w < 10 && !hit; w++) begin
                @(posedge clk); #1;
                hit = (s_terr === 1'b1);
            end
            s_cyc = '0;
            repeat (2) begin
                @(posedge clk); #1;
            end
            want = (k < 15) ? k : 15;
            checks++;
            if (!hit || s_cnt !== 4'(want) || s_gnt !== '0
                || s_kill !== 1'b0 || s_tgnt !== 5'b00001) begin
                errors++;
                $display("FAIL sat_cnt: k %0d hit %0d cnt %0d want %0d gnt %b kill %b tgnt %b",
                         k, hit, s_cnt, want, s_gnt, s_kill, s_tgnt);
            end
        end
        s_stb = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_ack_terminal();
        test_rst_drain();
        test_random();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
